// File: rtl/o3_rr_arb_pkg.sv
// Shared types and constants for the three-input round-robin arbiter.
// Source indices, lock-state encoding and the wrap-around increment helper.
// Pure declarations, no logic of its own.
package o3_rr_arb_pkg;

    localparam int SRC_W = 2;

    localparam logic [SRC_W-1:0] SRC_I0 = 2'd0;
    localparam logic [SRC_W-1:0] SRC_I1 = 2'd1;
    localparam logic [SRC_W-1:0] SRC_I2 = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } lock_st_e;

    // Next source index in round-robin order; 2 wraps back to 0.
    function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] s);
        return (s == SRC_I2) ? SRC_I0 : s + 2'd1;
    endfunction

endpackage

// File: rtl/o3_rr_arb_if.sv
// Handshake bundle for the three-input arbiter: three sources plus one consumer.
// Wiring only, no latency.
// Ready signals travel against valid; the consumer drives q_r.
interface o3_rr_arb_if
    import o3_rr_arb_pkg::*;
#(
    parameter int DW = 8
);
    logic             i0_v;
    logic [DW-1:0]    i0_d;
    logic             i0_r;
    logic             i1_v;
    logic [DW-1:0]    i1_d;
    logic             i1_r;
    logic             i2_v;
    logic [DW-1:0]    i2_d;
    logic             i2_r;
    logic             q_v;
    logic [DW-1:0]    q_d;
    logic [SRC_W-1:0] q_src;
    logic             q_r;
    logic             any_req;

    // Arbiter side.
    modport slave (
        input  i0_v, i0_d, i1_v, i1_d, i2_v, i2_d, q_r,
        output i0_r, i1_r, i2_r, q_v, q_d, q_src, any_req
    );

    // Sources and consumer side.
    modport master (
        output i0_v, i0_d, i1_v, i1_d, i2_v, i2_d, q_r,
        input  i0_r, i1_r, i2_r, q_v, q_d, q_src, any_req
    );

endinterface

// File: rtl/o3_rr_arb_pick.sv
// Winner select: wrap-around search from ptr, overridden by a held lock input.
// Purely combinational.
// No flow control of its own; the caller qualifies the result with its load enable.
module o3_rr_pick
    import o3_rr_arb_pkg::*;
(
    input  logic [SRC_W-1:0] i_ptr,
    input  logic [2:0]       i_v,
    input  logic             i_lock,
    input  logic [SRC_W-1:0] i_held,
    output logic [SRC_W-1:0] o_winner,
    output logic             o_win_v
);

    logic [SRC_W-1:0] w_c;

    // Held input wins while still valid; otherwise first valid in order ptr, ptr+1, ptr+2.
    always_comb begin
        o_winner = SRC_I0;
        o_win_v  = 1'b0;
        w_c      = i_ptr;
        if (i_lock && i_v[i_held]) begin
            o_winner = i_held;
            o_win_v  = 1'b1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!o_win_v && i_v[w_c]) begin
                    o_winner = w_c;
                    o_win_v  = 1'b1;
                end
                w_c = next_src(w_c);
            end
        end
    end

endmodule

// File: rtl/o3_rr_arb.sv
// Three-input round-robin arbiter with optional burst lock and a registered output.
// Latency: one cycle from accepted input beat to q_v/q_d/q_src.
// Backpressure: q_r low with q_v high stalls the register, drops every input ready, freezes ptr.
module o3_rr_arb
    import o3_rr_arb_pkg::*;
#(
    parameter int DW   = 8,
    parameter bit LOCK = 1'b0
)(
    input  logic          ck,
    input  logic          nrst,
    o3_rr_arb_if.slave    bus
);

    logic                 r_q_v;
    logic [DW-1:0]        r_q_d;
    logic [SRC_W-1:0]     r_q_src;
    logic [SRC_W-1:0]     r_ptr;
    lock_st_e             r_state;
    logic [SRC_W-1:0]     r_held;

    logic [2:0]           w_v;
    logic                 w_lock_en;
    logic                 w_lock_hit;
    logic [SRC_W-1:0]     w_winner;
    logic                 w_win_v;
    logic                 w_ld;
    logic                 w_xfer;
    logic [DW-1:0]        w_win_d;

    assign w_v        = {bus.i2_v, bus.i1_v, bus.i0_v};
    assign w_lock_en  = LOCK && (r_state == HELD);
    assign w_lock_hit = w_lock_en && w_v[r_held];

    o3_rr_pick u_pick (
        .i_ptr    (r_ptr),
        .i_v      (w_v),
        .i_lock   (w_lock_en),
        .i_held   (r_held),
        .o_winner (w_winner),
        .o_win_v  (w_win_v)
    );

    // The output register can take a beat when empty or when its beat leaves this cycle.
    assign w_ld   = !r_q_v || bus.q_r;
    assign w_xfer = w_ld && w_win_v;

    // Only the winner sees ready. With nobody requesting, every ready follows ld:
    // harmless since no valid is up, and it is what sources see straight out of reset.
    assign bus.i0_r = w_ld && (!w_win_v || (w_winner == SRC_I0));
    assign bus.i1_r = w_ld && (!w_win_v || (w_winner == SRC_I1));
    assign bus.i2_r = w_ld && (!w_win_v || (w_winner == SRC_I2));

    assign bus.any_req = |w_v;

    // Route the winning source's data toward the output register.
    always_comb begin
        w_win_d = bus.i0_d;
        case (w_winner)
            SRC_I1:  w_win_d = bus.i1_d;
            SRC_I2:  w_win_d = bus.i2_d;
            default: w_win_d = bus.i0_d;
        endcase
    end

    // Output register: load the winner, or drain when nothing is requesting; hold on stall.
    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            r_q_v   <= 1'b0;
            r_q_d   <= '0;
            r_q_src <= SRC_I0;
        end else if (w_ld) begin
            if (w_win_v) begin
                r_q_v   <= 1'b1;
                r_q_d   <= w_win_d;
                r_q_src <= w_winner;
            end else begin
                r_q_v   <= 1'b0;
            end
        end
    end

    // Priority pointer moves past each winner, but not while a burst lock carries the grant.
    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            r_ptr <= SRC_I0;
        end else if (w_xfer && !w_lock_hit) begin
            r_ptr <= next_src(w_winner);
        end
    end

    // Burst-lock FSM: grab on a transfer, release the cycle the held source drops valid.
    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_held  <= SRC_I0;
        end else if (LOCK) begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_state <= HELD;
                        r_held  <= w_winner;
                    end
                end
                HELD: begin
                    if (w_xfer) begin
                        r_state <= HELD;
                        r_held  <= w_winner;
                    end else if (!w_v[r_held]) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.q_v   = r_q_v;
    assign bus.q_d   = r_q_d;
    assign bus.q_src = r_q_src;

endmodule

// File: tb/tb_o3_rr_arb.sv
// Bench for o3_rr_arb: one instance without and one with burst lock, fed the same stimulus.
// Each instance is compared every cycle against a reference model of the arbitration rules.
// Directed scenarios add fixed expected sequences on top of the model.
module tb_o3_rr_arb;
    import o3_rr_arb_pkg::*;

    logic       ck   = 1'b0;
    logic       nrst = 1'b0;
    logic [2:0] tv   = 3'b000;
    logic [7:0] td [3];
    logic       tqr  = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    o3_rr_arb_if #(.DW(8)) bus0 ();
    o3_rr_arb_if #(.DW(8)) bus1 ();

    assign bus0.i0_v = tv[0]; assign bus0.i1_v = tv[1]; assign bus0.i2_v = tv[2];
    assign bus0.i0_d = td[0]; assign bus0.i1_d = td[1]; assign bus0.i2_d = td[2];
    assign bus0.q_r  = tqr;
    assign bus1.i0_v = tv[0]; assign bus1.i1_v = tv[1]; assign bus1.i2_v = tv[2];
    assign bus1.i0_d = td[0]; assign bus1.i1_d = td[1]; assign bus1.i2_d = td[2];
    assign bus1.q_r  = tqr;

    o3_rr_arb #(.DW(8), .LOCK(1'b0)) u_arb0 (.ck(ck), .nrst(nrst), .bus(bus0.slave));
    o3_rr_arb #(.DW(8), .LOCK(1'b1)) u_arb1 (.ck(ck), .nrst(nrst), .bus(bus1.slave));

    always #5 ck = ~ck;

    // Reference model state, index 0 = no lock, 1 = burst lock.
    bit         m_qv   [2];
    logic [7:0] m_qd   [2];
    logic [1:0] m_src  [2];
    int         m_ptr  [2];
    bit         m_held [2];
    int         m_hk   [2];
    // Per-cycle derived values.
    int          e_w   [2];
    bit          e_wv  [2];
    bit          e_hit [2];
    bit          e_ld  [2];
    logic [14:0] e_obs [2];

    function automatic logic [14:0] obs(input int m);
        if (m == 0)
            return {bus0.q_v, bus0.q_d, bus0.q_src, bus0.i2_r, bus0.i1_r, bus0.i0_r, bus0.any_req};
        return {bus1.q_v, bus1.q_d, bus1.q_src, bus1.i2_r, bus1.i1_r, bus1.i0_r, bus1.any_req};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_qv[m] = 0; m_qd[m] = 8'h00; m_src[m] = 2'd0;
            m_ptr[m] = 0; m_held[m] = 0; m_hk[m] = 0;
        end
    endtask

    // Who wins now, who gets ready, and what the outputs should read.
    task automatic model_comb();
        logic [2:0] rdy;
        for (int m = 0; m < 2; m++) begin
            e_hit[m] = (m == 1) && m_held[m] && tv[m_hk[m]];
            e_wv[m]  = 0;
            e_w[m]   = 0;
            if (e_hit[m]) begin
                e_w[m] = m_hk[m]; e_wv[m] = 1;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    int idx;
                    idx = (m_ptr[m] + k) % 3;
                    if (!e_wv[m] && tv[idx]) begin e_w[m] = idx; e_wv[m] = 1; end
                end
            end
            e_ld[m] = !m_qv[m] || tqr;
            for (int k = 0; k < 3; k++) rdy[k] = e_ld[m] && (!e_wv[m] || e_w[m] == k);
            e_obs[m] = {m_qv[m], m_qd[m], m_src[m], rdy, |tv};
        end
    endtask

    // Advance the model across one rising edge.
    task automatic model_clock();
        bit xfer;
        model_comb();
        for (int m = 0; m < 2; m++) begin
            xfer = e_ld[m] && e_wv[m];
            if (e_ld[m]) begin
                if (e_wv[m]) begin
                    m_qv[m]  = 1;
                    m_qd[m]  = td[e_w[m]];
                    m_src[m] = 2'(e_w[m]);
                    if (!e_hit[m]) m_ptr[m] = (e_w[m] + 1) % 3;
                end else begin
                    m_qv[m] = 0;
                end
            end
            if (m == 1) begin
                if (xfer) begin m_held[m] = 1; m_hk[m] = e_w[m]; end
                else if (m_held[m] && !tv[m_hk[m]]) m_held[m] = 0;
            end
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic qr);
        tv = v; td[0] = a; td[1] = b; td[2] = c; tqr = qr;
    endtask

    // Pulse reset at a falling edge and resync the model; leaves the bench just past a rising edge.
    task automatic do_reset();
        @(negedge ck);
        nrst = 1'b0; tv = 3'b000; tqr = 1'b0;
        model_reset();
        #2 nrst = 1'b1;
        @(posedge ck); model_clock(); #1;
    endtask

    task automatic test_reset();
        drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
        #2;
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (obs(m) !== {1'b0, 8'h00, 2'd0, 3'b111, 1'b0}) begin
                n_bad++; $display("FAIL reset_state dut%0d got %h want %h", m, obs(m), {1'b0, 8'h00, 2'd0, 3'b111, 1'b0});
            end
        end
        @(negedge ck); nrst = 1'b1;
        @(posedge ck); model_clock(); #1;
        // One beat lands and stalls, then reset hits it mid-flight.
        drive(3'b001, 8'hA5, 8'h00, 8'h00, 1'b0);
        @(negedge ck); model_comb();
        @(posedge ck); model_clock(); #1;
        @(negedge ck); model_comb();
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (obs(m) !== e_obs[m]) begin
                n_bad++; $display("FAIL reset_preload dut%0d got %h want %h", m, obs(m), e_obs[m]);
            end
        end
        nrst = 1'b0; #1;
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (obs(m) >> 4 !== 15'h0) begin
                n_bad++; $display("FAIL reset_async dut%0d got q %h want 0", m, obs(m) >> 4);
            end
        end
        model_reset(); tv = 3'b000; #1 nrst = 1'b1;
        @(posedge ck); model_clock(); #1;
        @(negedge ck);
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (obs(m) !== {1'b0, 8'h00, 2'd0, 3'b111, 1'b0}) begin
                n_bad++; $display("FAIL reset_release dut%0d got %h want %h", m, obs(m), {1'b0, 8'h00, 2'd0, 3'b111, 1'b0});
            end
        end
        @(posedge ck); model_clock(); #1;
    endtask

    task automatic test_round_robin();
        do_reset();
        drive(3'b111, 8'h10, 8'h11, 8'h12, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(negedge ck); model_comb();
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (obs(m) !== e_obs[m]) begin
                    n_bad++; $display("FAIL rr_model dut%0d cyc%0d got %h want %h", m, c, obs(m), e_obs[m]);
                end
            end
            if (c >= 1) begin
                n_cmp++;
                if ({bus0.q_v, bus0.q_src, bus0.q_d} !== {1'b1, 2'((c - 1) % 3), 8'(8'h10 + (c - 1) % 3)}) begin
                    n_bad++; $display("FAIL rr_seq cyc%0d got v%0d src%0d d%h want src%0d", c, bus0.q_v, bus0.q_src, bus0.q_d, (c - 1) % 3);
                end
            end
            @(posedge ck); model_clock(); #1;
        end
    endtask

    task automatic test_backpressure();
        logic qr_tab [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(3'b111, 8'h30 + 8'(c), 8'h40 + 8'(c), 8'h50 + 8'(c), qr_tab[c]);
            @(negedge ck); model_comb();
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (obs(m) !== e_obs[m]) begin
                    n_bad++; $display("FAIL bp_model dut%0d cyc%0d got %h want %h", m, c, obs(m), e_obs[m]);
                end
            end
            if (!qr_tab[c]) begin
                n_cmp++;
                if ({bus0.i2_r, bus0.i1_r, bus0.i0_r, bus1.i2_r, bus1.i1_r, bus1.i0_r} !== 6'b0) begin
                    n_bad++; $display("FAIL bp_ready cyc%0d got %b%b%b want 000", c, bus0.i2_r, bus0.i1_r, bus0.i0_r);
                end
            end
            @(posedge ck); model_clock(); #1;
        end
    endtask

    task automatic test_wrap();
        logic [2:0] v_tab [4] = '{3'b010, 3'b001, 3'b110, 3'b000};
        logic [1:0] s_tab [4] = '{2'd1, 2'd0, 2'd1, 2'd1};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(v_tab[c], 8'h60, 8'h61, 8'h62, 1'b1);
            @(negedge ck); model_comb();
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (obs(m) !== e_obs[m]) begin
                    n_bad++; $display("FAIL wrap_model dut%0d cyc%0d got %h want %h", m, c, obs(m), e_obs[m]);
                end
            end
            @(posedge ck); model_clock(); #1;
            @(negedge ck);
            n_cmp++;
            if (bus0.q_src !== s_tab[c] || (c < 3 && bus0.q_v !== 1'b1)) begin
                n_bad++; $display("FAIL wrap_src step%0d got %0d want %0d", c, bus0.q_src, s_tab[c]);
            end
            @(posedge ck); tv = 3'b000; model_clock(); #1;
        end
    endtask

    task automatic test_lock();
        logic [2:0] v_tab [6] = '{3'b010, 3'b111, 3'b111, 3'b101, 3'b001, 3'b000};
        logic [2:0] s_tab [6] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd0, 3'd4};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(v_tab[c], 8'h20, 8'h21, 8'h22, 1'b1);
            @(negedge ck); model_comb();
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (obs(m) !== e_obs[m]) begin
                    n_bad++; $display("FAIL lock_model dut%0d cyc%0d got %h want %h", m, c, obs(m), e_obs[m]);
                end
            end
            @(posedge ck); model_clock(); #1;
            @(negedge ck);
            n_cmp++;
            if ((s_tab[c] == 3'd4) ? (bus1.q_v !== 1'b0)
                                   : ({bus1.q_v, bus1.q_src} !== {1'b1, s_tab[c][1:0]})) begin
                n_bad++; $display("FAIL lock_src step%0d got v%0d src%0d want code %0d", c, bus1.q_v, bus1.q_src, s_tab[c]);
            end
            @(posedge ck); model_clock(); #1;
        end
    endtask

    task automatic test_drain_any();
        do_reset();
        drive(3'b100, 8'h00, 8'h00, 8'h5C, 1'b1);
        @(posedge ck); model_clock(); #1;
        tv = 3'b000;
        @(negedge ck);
        n_cmp++;
        if ({bus0.q_v, bus0.q_src, bus0.q_d} !== {1'b1, 2'd2, 8'h5C}) begin
            n_bad++; $display("FAIL drain_load got v%0d src%0d d%h want v1 src2 d5c", bus0.q_v, bus0.q_src, bus0.q_d);
        end
        @(posedge ck); model_clock(); #1;
        @(negedge ck); model_comb();
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (obs(m) !== {1'b0, 8'h5C, 2'd2, 3'b111, 1'b0} || obs(m) !== e_obs[m]) begin
                n_bad++; $display("FAIL drain_empty dut%0d got %h want %h", m, obs(m), e_obs[m]);
            end
        end
        for (int c = 0; c < 8; c++) begin
            tv = 3'(c); #1;
            n_cmp++;
            if ({bus0.any_req, bus1.any_req} !== {2{|tv}}) begin
                n_bad++; $display("FAIL any_req v=%b got %b%b want %b", tv, bus0.any_req, bus1.any_req, |tv);
            end
        end
        tv = 3'b000;
        @(posedge ck); model_clock(); #1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
                  $urandom_range(0, 3) != 0);
            @(negedge ck); model_comb();
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (obs(m) !== e_obs[m]) begin
                    n_bad++; $display("FAIL rand dut%0d cyc%0d got %h want %h", m, c, obs(m), e_obs[m]);
                end
            end
            @(posedge ck); model_clock(); #1;
        end
    endtask

    initial begin
        td[0] = 8'h00; td[1] = 8'h00; td[2] = 8'h00;
        model_reset();
        test_reset();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_lock();
        test_drain_any();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/o3_rr_arb.md
Name: o3_rr_arb

Overview:
- Three-input round-robin arbiter with a registered valid/ready output.
- Sits directly downstream of the 3-input OR cell: the OR of the three request lines forms the "any request" wake term. This block resolves which requester wins, transfers its data and returns per-input ready.
- Used wherever three event/data sources share one consumer, e.g. interrupt or test-access aggregation in the standard-cell demo designs.

Parameters:
- DW, 8, data width per input and output.
- LOCK, 0, 1 = once granted, an input keeps the grant while its valid stays high (burst lock); 0 = re-arbitrate every beat.

Ports:
- ck  input  1  clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- i0_v  input  1  input 0 valid.
- i0_d  input  DW  input 0 data.
- i0_r  output  1  input 0 ready.
- i1_v, i1_d, i1_r  as input 0, for input 1.
- i2_v, i2_d, i2_r  as input 0, for input 2.
- q_v  output  1  output valid (registered).
- q_d  output  DW  output data (registered).
- q_src  output  2  index of the input that produced q_d (0..2; 3 never driven).
- q_r  input  1  output ready from the consumer.
- any_req  output  1  combinational i0_v | i1_v | i2_v.

Behaviour:
- Clock and reset: one clock ck; reset nrst is asynchronous and active-low.
- Reset values: q_v=0, q_d=0, q_src=0, priority pointer ptr=0 (input 0 highest), lock state=IDLE. i*_r follows its combinational equation, so all i*_r=1 directly after reset.
- Output register state "empty" = !q_v.
- Load enable: ld = !q_v | q_r. When ld=1 the register accepts the arbitration winner, or clears q_v if there is none.
- Ready:
  - i*_r=1 only for the current winner and only when ld=1; all others are 0.
  - No combinational path from i*_v to i*_r other than through the winner select.
  - No combinational path from q_r to q_v.
- Round-robin rule:
  - Search order starts at ptr and wraps: ptr, ptr+1, ptr+2 mod 3.
  - The first input with valid=1 wins.
  - On each transfer (winner valid & ld), ptr <= (winner+1) mod 3. Wrap: winner 2 gives ptr 0.
- Transfer: on an accepted beat, q_d <= winner data, q_src <= winner index, q_v <= 1 at the next edge. Latency input to output = 1 cycle.
- Drain: if ld=1 and no input is valid, q_v <= 0; q_d and q_src hold their old values.
- Stall: q_v=1 and q_r=0 means q_v, q_d and q_src all hold, all i*_r=0, and ptr holds.
- Throughput: 1 beat/cycle when q_r is held at 1.
- Lock FSM (LOCK=1 only):
  - States IDLE and HELD(k).
  - IDLE -> HELD(k) on a transfer from input k.
  - HELD(k) keeps input k as winner while ik_v=1, regardless of ptr. ptr is not advanced while held.
  - HELD(k) -> IDLE in the cycle ik_v is sampled 0; arbitration resumes in that same cycle from ptr.
  - LOCK=0: the FSM stays in IDLE.
- Simultaneous events: a transfer and a drain cannot both happen; the register is loaded or cleared per ld. A new beat may load in the same cycle the old beat leaves (q_v stays 1).
- Reset mid-operation: an asserted nrst immediately clears q_v, ptr and the lock state. An in-flight beat is dropped, with no partial update.
- Sources must hold i*_v/i*_d until their ready; the block does not check this.

Decomposition:
- Shared package:
  - SRC_W=2.
  - Source index constants SRC_I0=0, SRC_I1=1, SRC_I2=2.
  - Lock state encoding IDLE/HELD.
- One natural sub-module: o3_rr_pick. It is purely combinational: inputs ptr[1:0], v[2:0], lock/held index; outputs winner[1:0], win_v. It holds the wrap-around search.
- The top level keeps the registers, ld and ready logic, and any_req.

Test Plan:
- Reset: nrst low mid-beat with q_v=1, q_d=0xA5 -> q_v=0, q_d=0, q_src=0 asynchronously; after release all i*_r=1 and any_req=0.
- All three valid continuously with q_r=1, data 0x10/0x11/0x12 -> q_src sequence 0,1,2,0,1,2 and q_d 0x10,0x11,0x12 repeating; one beat/cycle after 1-cycle latency.
- Backpressure: q_r=0 for 4 cycles while q_v=1 -> q_d/q_src stable, all i*_r=0; q_r=1 -> next winner loads that same edge.
- Wrap: ptr=2 with only i0_v=1 -> winner 0, then ptr=1; i2 and i1 both valid -> i1 wins.
- LOCK=1: i1_v high for 3 beats with i0, i2 also valid -> q_src=1,1,1; i1_v drops -> next beat from i2, then i0.
- Drain/any_req: single beat from i2 then all valid low -> q_v falls the cycle after acceptance; any_req tracks the OR of i*_v combinationally at every input combination (8 cases).
